// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, hazard controls
// and the values presented to the fetch-to-decode pipeline register.
interface fetch_unit_if;
  logic        stall_f;
  logic        redirect_e;
  logic [31:0] redirect_pc_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] pc_plus_4_f;
  logic [31:0] inst_f;
  logic        inst_valid_f;

  // Handshakes: a request transfers on a cycle where imem_req && imem_ready;
  // a response transfers on any cycle with imem_rvalid (no back-pressure),
  // and at most one request is outstanding; the pipeline register consumes
  // the fetched instruction on a cycle with inst_valid_f && !stall_f.
  modport master (
    input  stall_f, redirect_e, redirect_pc_e, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, pc_f, pc_plus_4_f, inst_f, inst_valid_f
  );

  modport slave (
    output stall_f, redirect_e, redirect_pc_e, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, pc_f, pc_plus_4_f, inst_f, inst_valid_f
  );
endinterface

// File: rtl/fetch_unit.sv
// RISC-V fetch stage: owns the PC, issues one instruction-memory request at a
// time and feeds the fetch/decode register, inserting NOPs when nothing is held.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic [31:0] target;
  logic        unused_ok;

  assign target    = {bus.redirect_pc_e[31:2], 2'b00};
  assign unused_ok = &{1'b0, bus.redirect_pc_e[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      state    <= REQ;
      inst_buf <= NOP_INST;
    end else begin
      case (state)
        REQ: begin
          if (bus.redirect_e) begin
            pc <= target;
            // A request accepted alongside a redirect fetches the wrong PC.
            if (bus.imem_ready) state <= DROP;
          end else if (bus.imem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.redirect_e) begin
            pc    <= target;
            state <= bus.imem_rvalid ? REQ : DROP;
          end else if (bus.imem_rvalid) begin
            inst_buf <= bus.imem_rdata;
            state    <= HOLD;
          end
        end
        DROP: begin
          // The stale response always ends DROP; a concurrent redirect only moves pc.
          if (bus.redirect_e) pc <= target;
          if (bus.imem_rvalid) state <= REQ;
        end
        HOLD: begin
          if (bus.redirect_e) begin
            pc    <= target;
            state <= REQ;
          end else if (!bus.stall_f) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  assign bus.imem_req     = (state == REQ);
  assign bus.imem_addr    = {pc[31:2], 2'b00};
  assign bus.pc_f         = pc;
  assign bus.pc_plus_4_f  = pc + 32'd4;
  assign bus.inst_f       = (state == HOLD) ? inst_buf : NOP_INST;
  assign bus.inst_valid_f = (state == HOLD);
  assign state_dbg        = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// against a transaction-level model of PC flow and a scoreboard queue.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [1:0]  ST_REQ  = 2'd0;
  localparam logic [1:0]  ST_WAIT = 2'd1;
  localparam logic [1:0]  ST_HOLD = 2'd2;
  localparam logic [1:0]  ST_DROP = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];        // {pc, instruction} expected on the next HOLD

  // Reference model state
  logic [31:0] exp_pc;
  bit          outstanding;
  bit          stale;
  bit          holding;
  logic [31:0] req_addr;
  int          lat;

  // Stimulus configuration
  bit          random_mode = 0;
  int          lat_cfg = 0;
  bit          use_override = 0;
  logic [31:0] override_word = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0010_0113;
      default:       mem_word = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  // ---------------- reference model (updates on each edge) ----------------
  initial begin
    bit acc;
    bit resp;
    bit redir;
    forever begin
      @(posedge clk);
      if (!reset) begin
        exp_pc      = RESET_PC;
        outstanding = 0;
        stale       = 0;
        holding     = 0;
        exp_q.delete();
      end else begin
        acc   = !outstanding && !holding && bus.imem_ready;
        resp  = outstanding && bus.imem_rvalid;
        redir = bus.redirect_e;
        if (bus.imem_rvalid) check("rvalid_protocol", {31'b0, outstanding}, 32'd1);
        if (holding && (redir || !bus.stall_f)) begin
          holding = 0;
          if (!redir) exp_pc = exp_pc + 32'd4;
        end
        if (resp) begin
          outstanding = 0;
          if (!stale && !redir) begin
            exp_q.push_back({req_addr, bus.imem_rdata});
            holding = 1;
          end
        end
        if (acc) begin
          outstanding = 1;
          stale       = 0;
          req_addr    = {exp_pc[31:2], 2'b00};
          lat         = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 2));
        end
        if (redir) begin
          exp_pc = {bus.redirect_pc_e[31:2], 2'b00};
          if (outstanding) stale = 1;
        end
      end
    end
  end

  // ---------------- driver: memory responder + random stimulus ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (outstanding && lat == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = use_override ? override_word : mem_word(req_addr);
      end else begin
        if (outstanding) lat--;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
      if (random_mode) begin
        bus.imem_ready    = ($urandom_range(0, 3) != 0);
        bus.stall_f       = ($urandom_range(0, 2) == 0);
        bus.redirect_e    = ($urandom_range(0, 9) == 0);
        bus.redirect_pc_e = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                        : $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [63:0] cur;
    logic        prev_valid;
    cur        = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
      end else begin
        check("pc_f", bus.pc_f, exp_pc);
        check("pc_plus_4_f", bus.pc_plus_4_f, exp_pc + 32'd4);
        check("imem_req", {31'b0, bus.imem_req}, {31'b0, !outstanding && !holding});
        if (bus.imem_req) check("imem_addr", bus.imem_addr, {exp_pc[31:2], 2'b00});
        check("inst_valid_f", {31'b0, bus.inst_valid_f}, {31'b0, holding});
        if (bus.inst_valid_f && !prev_valid) begin
          check("sb_pending", exp_q.size(), 32'd1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("hold_pc", bus.pc_f, cur[63:32]);
            check("hold_inst", bus.inst_f, cur[31:0]);
          end
        end else if (bus.inst_valid_f) begin
          check("hold_inst_stable", bus.inst_f, cur[31:0]);
        end else begin
          check("inst_f_nop", bus.inst_f, NOP_INST);
        end
        prev_valid = bus.inst_valid_f;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_state(input logic [1:0] st, input string name);
    int n;
    n = 0;
    while (state_dbg != st && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg != st) check({"timeout_", name}, {30'b0, state_dbg}, {30'b0, st});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset             = 1'b0;
    bus.imem_ready    = 1'b1;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.stall_f       = 1'b0;
    bus.redirect_e    = 1'b0;
    bus.redirect_pc_e = 32'h0;
    lat_cfg           = 0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, bus.imem_req}, 32'd1);
    check("rst_addr", bus.imem_addr, RESET_PC);
    check("rst_inst", bus.inst_f, NOP_INST);
    check("rst_valid", {31'b0, bus.inst_valid_f}, 32'd0);
    reset = 1'b1;

    // Basic fetch from reset
    @(negedge clk);
    wait_state(ST_HOLD, "t1_hold");
    check("t1_inst", bus.inst_f, 32'h0050_0093);
    check("t1_pc", bus.pc_f, 32'h0);
    check("t1_pc4", bus.pc_plus_4_f, 32'h4);

    // Stall in HOLD for 4 cycles
    bus.stall_f = 1'b1;
    repeat (4) @(negedge clk);
    check("t2_pc", bus.pc_f, 32'h0);
    check("t2_inst", bus.inst_f, 32'h0050_0093);
    check("t2_valid", {31'b0, bus.inst_valid_f}, 32'd1);
    check("t2_noreq", {31'b0, bus.imem_req}, 32'd0);
    bus.stall_f = 1'b0;
    @(negedge clk);
    check("t2_req_after", {31'b0, bus.imem_req}, 32'd1);
    check("t2_addr_after", bus.imem_addr, 32'h4);

    // Redirect in WAIT, late response must be dropped
    lat_cfg       = 2;
    use_override  = 1;
    override_word = 32'hDEAD_BEEF;
    @(negedge clk);
    wait_state(ST_WAIT, "t3_wait");
    bus.redirect_e    = 1'b1;
    bus.redirect_pc_e = 32'h100;
    @(negedge clk);
    bus.redirect_e = 1'b0;
    check("t3_drop", {30'b0, state_dbg}, {30'b0, ST_DROP});
    wait_state(ST_REQ, "t3_req");
    check("t3_addr", bus.imem_addr, 32'h100);
    use_override = 0;

    // Redirect in REQ coinciding with acceptance
    bus.redirect_e    = 1'b1;
    bus.redirect_pc_e = 32'h203;
    @(negedge clk);
    bus.redirect_e = 1'b0;
    check("t4_drop", {30'b0, state_dbg}, {30'b0, ST_DROP});
    check("t4_pc", bus.pc_f, 32'h200);
    wait_state(ST_REQ, "t4_req");
    check("t4_addr", bus.imem_addr, 32'h200);

    // Redirect in HOLD to the top of the address space, then wrap
    lat_cfg = 0;
    wait_state(ST_HOLD, "t5_hold0");
    bus.redirect_e    = 1'b1;
    bus.redirect_pc_e = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect_e = 1'b0;
    check("t5_redir_req", {30'b0, state_dbg}, {30'b0, ST_REQ});
    wait_state(ST_HOLD, "t5_hold");
    check("t5_pc", bus.pc_f, 32'hFFFF_FFFC);
    check("t5_pc4", bus.pc_plus_4_f, 32'h0);
    @(negedge clk);
    check("t5_wrap_req", {31'b0, bus.imem_req}, 32'd1);
    check("t5_wrap_addr", bus.imem_addr, 32'h0);

    // Redirect beats stall in HOLD
    wait_state(ST_HOLD, "t6_hold");
    bus.stall_f       = 1'b1;
    bus.redirect_e    = 1'b1;
    bus.redirect_pc_e = 32'h40;
    @(negedge clk);
    bus.stall_f    = 1'b0;
    bus.redirect_e = 1'b0;
    check("t6_redir_wins", {30'b0, state_dbg}, {30'b0, ST_REQ});
    check("t6_addr", bus.imem_addr, 32'h40);

    // Asynchronous reset in the middle of WAIT
    lat_cfg = 2;
    @(negedge clk);
    wait_state(ST_WAIT, "t6_wait");
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", {31'b0, bus.imem_req}, 32'd1);
    check("arst_addr", bus.imem_addr, RESET_PC);
    check("arst_inst", bus.inst_f, NOP_INST);
    check("arst_state", {30'b0, state_dbg}, {30'b0, ST_REQ});
    check("arst_pc", bus.pc_f, RESET_PC);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Randomized traffic
    lat_cfg     = -1;
    random_mode = 1;
    repeat (3000) @(negedge clk);
    random_mode       = 0;
    bus.stall_f       = 1'b0;
    bus.redirect_e    = 1'b0;
    bus.imem_ready    = 1'b1;
    repeat (12) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
